flash_verify: RTL and testbench
===============================

Name: flash_verify

Overview:
- Downstream consumer of the SPI-flash write/read-back controller's read stream (rddata/rddata_vld/rddone).
- Checks each read-back byte against the known write pattern, counts bytes and mismatches, and flags a watchdog timeout.
- Publishes a per-round pass/fail result and drives board LEDs.
- Sits between the flash control block and the top-level LED/debug pins.

Parameters:
- DATA_BYTE, 64, bytes expected per read round (1..64).
- PATTERN_OFS, 4, expected byte i = (i + PATTERN_OFS) mod 256.
- TIMEOUT, 250000, max idle cycles inside a round before abort (5 ms at 50 MHz).
- HB_CYCLES, 25000000, heartbeat LED half-period in clk cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rddata  in  8  read-back byte
- rddata_vld  in  1  rddata valid, one cycle per byte
- rddone  in  1  one-cycle end-of-round pulse
- result_vld  out  1  one-cycle pulse: result fields updated
- pass  out  1  last round passed
- fail_sticky  out  1  set on any failed round; cleared only by rst
- timeout  out  1  last round ended by watchdog
- err_cnt  out  8  mismatches in last round, saturates at 255
- rx_cnt  out  7  bytes received in last round
- first_err_idx  out  6  index of first mismatch in last round (0 if none)
- first_err_data  out  8  byte received at first mismatch (0 if none)
- round_cnt  out  16  completed rounds, wraps 0xFFFF->0
- led  out  4  [0] heartbeat, [1] pass, [2] fail_sticky, [3] toggles each round

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters 0.
- States:
  - IDLE:
    - rddata_vld: byte checked as index 0 -> CHECK.
    - rddone with no vld: round closes with rx_cnt=0, which is a fail.
  - CHECK:
    - Each vld compares rddata against (idx+PATTERN_OFS)[7:0], then idx++.
    - Mismatch: err_cnt++ (saturating). On the first mismatch, latch idx and rddata.
    - Overrun (vld when idx==DATA_BYTE): counts as a mismatch; idx holds at DATA_BYTE; the byte is not compared.
    - rddone: close round -> IDLE.
    - Watchdog counter resets on every vld and counts otherwise. When it reaches TIMEOUT-1 the round closes with timeout=1 -> IDLE.
- vld and rddone in the same cycle: the byte is counted and checked first, then the round closes.
- Round close:
  - In the cycle after the closing event: result_vld=1 for exactly one cycle.
  - Result fields are registered together from the working counters, including the final byte.
  - pass = (err_cnt==0) & (rx_cnt==DATA_BYTE) & !timeout.
  - fail_sticky |= !pass; round_cnt++; led[3] toggles.
  - Working counters clear for the next round.
- Result outputs hold their values until the next round closes.
- rddata_vld arriving in the result_vld cycle begins a new round. It is accepted normally.
- Heartbeat: free-running counter toggles led[0] every HB_CYCLES cycles and is independent of state.
- rst mid-round aborts the round; no result_vld is produced.
- Widths:
  - idx and rx_cnt are 7 bits so that 64 is representable.
  - Expected-byte arithmetic is modulo 256.
  - first_err_idx reports idx[5:0].

Decomposition:
- Shared constants go in the existing project parameter include: DATA_BYTE, PATTERN_OFS, and the 5 ms delay constant used as TIMEOUT.
- State encodings are local one-hot localparams.
- One natural sub-module: led_heartbeat (counter plus toggle, parameter HB_CYCLES).

Test Plan:
- Good round: 64 bytes 0x04..0x43 with vld, then rddone -> one cycle later result_vld=1, pass=1, err_cnt=0, rx_cnt=64, round_cnt=1, fail_sticky=0.
- Corrupt bytes: byte 5=0xFF and byte 9=0x00, all others correct -> pass=0, err_cnt=2, first_err_idx=5, first_err_data=0xFF, fail_sticky=1.
- Short round: 10 correct bytes, then rddone -> pass=0, rx_cnt=10, err_cnt=0.
- Overrun plus final byte: 65 bytes, with rddone concurrent with the last vld -> rx_cnt=64, err_cnt=1, pass=0, and result_vld exactly one cycle after.
- Stall: 3 bytes then no input for TIMEOUT cycles -> timeout=1, pass=0, rx_cnt=3. A following good round gives pass=1 and timeout=0 while fail_sticky stays 1.
- Reset mid-round after 20 bytes -> all outputs 0, no result_vld. The next good round reports round_cnt=1.

Source files
------------

// File: rtl/flash_verify_pkg.sv
// Shared constants, state encoding and the expected-pattern helper for the
// flash read-back verifier.
package flash_verify_pkg;

  // Bytes expected in one read round (1..64).
  localparam int FV_DATA_BYTE   = 64;
  // Expected byte i is (i + FV_PATTERN_OFS) mod 256.
  localparam int FV_PATTERN_OFS = 4;
  // 5 ms at 50 MHz: idle cycles tolerated inside a round.
  localparam int FV_DELAY_5MS   = 250000;
  // Heartbeat LED half-period in clock cycles (0.5 s at 50 MHz).
  localparam int FV_HB_CYCLES   = 25000000;

  // One-hot round states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b01,
    ST_CHECK = 2'b10
  } state_e;

  // Expected read-back byte for a given index; wraps modulo 256.
  function automatic logic [7:0] exp_byte(input logic [6:0] idx, input logic [7:0] ofs);
    return {1'b0, idx} + ofs;
  endfunction

endpackage

// File: rtl/flash_verify_led_heartbeat.sv
// Free-running heartbeat: toggles the LED once every HB_CYCLES clocks,
// independent of any verification activity.
module flash_verify_led_heartbeat #(
  parameter int HB_CYCLES = 25000000
) (
  input  logic clk,
  input  logic rst,
  output logic led_o
);

  localparam int CW = (HB_CYCLES > 1) ? $clog2(HB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HB_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          led_q, led_d;

  // Count up to the half-period, then wrap and flip the LED.
  always_comb begin
    cnt_d = cnt_q;
    led_d = led_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      led_d = ~led_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
      led_d = led_q;
    end
  end

  // Heartbeat counter and LED registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      led_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/flash_verify.sv
// Read-back verifier: compares each byte of a flash read round against the
// known write pattern, counts bytes and mismatches, aborts a stalled round
// with a watchdog, and publishes a registered per-round result plus LEDs.
module flash_verify
  import flash_verify_pkg::*;
#(
  parameter int DATA_BYTE   = FV_DATA_BYTE,
  parameter int PATTERN_OFS = FV_PATTERN_OFS,
  parameter int TIMEOUT     = FV_DELAY_5MS,
  parameter int HB_CYCLES   = FV_HB_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rddata,
  input  logic        rddata_vld,
  input  logic        rddone,
  output logic        result_vld,
  output logic        pass,
  output logic        fail_sticky,
  output logic        timeout,
  output logic [7:0]  err_cnt,
  output logic [6:0]  rx_cnt,
  output logic [5:0]  first_err_idx,
  output logic [7:0]  first_err_data,
  output logic [15:0] round_cnt,
  output logic [3:0]  led
);

  localparam logic [6:0]  DB7     = 7'(DATA_BYTE);
  localparam logic [7:0]  OFS8    = 8'(PATTERN_OFS);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  // Round state and working counters.
  state_e      state_q, state_d, state_nx_s;
  logic [6:0]  idx_q, idx_d, idx_n;
  logic [7:0]  err_q, err_d, err_n;
  logic        ferr_q, ferr_d, ferr_n;
  logic [5:0]  fidx_q, fidx_d, fidx_n;
  logic [7:0]  fdata_q, fdata_d, fdata_n;
  logic [31:0] wd_q, wd_d, wd_nx_s;
  logic        mism_s, to_s, close_s, pass_s;

  // Published results.
  logic        result_vld_q, pass_q, fail_sticky_q, timeout_q, led_rnd_q;
  logic [7:0]  err_cnt_q, first_err_data_q;
  logic [6:0]  rx_cnt_q;
  logic [5:0]  first_err_idx_q;
  logic [15:0] round_cnt_q;
  logic        hb_led_s;

  // Account for the current byte; an overrun byte is a mismatch but is
  // never compared and leaves the index parked at DATA_BYTE.
  always_comb begin
    idx_n   = idx_q;
    err_n   = err_q;
    ferr_n  = ferr_q;
    fidx_n  = fidx_q;
    fdata_n = fdata_q;
    mism_s  = 1'b0;
    if (rddata_vld) begin
      if (idx_q >= DB7) begin
        mism_s = 1'b1;
        idx_n  = idx_q;
      end else begin
        mism_s = (rddata != exp_byte(idx_q, OFS8));
        idx_n  = idx_q + 7'd1;
      end
    end else begin
      mism_s = 1'b0;
    end
    if (mism_s) begin
      err_n = (err_q == 8'hFF) ? 8'hFF : (err_q + 8'd1);
      if (!ferr_q) begin
        ferr_n  = 1'b1;
        fidx_n  = idx_q[5:0];
        fdata_n = rddata;
      end else begin
        ferr_n  = ferr_q;
      end
    end else begin
      err_n = err_q;
    end
  end

  // Next state and watchdog; an explicit end-of-round wins over the watchdog.
  always_comb begin
    state_nx_s = state_q;
    wd_nx_s    = wd_q;
    to_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wd_nx_s = 32'd0;
        if (rddata_vld) begin
          state_nx_s = ST_CHECK;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        state_nx_s = ST_CHECK;
        if (rddata_vld) begin
          wd_nx_s = 32'd0;
        end else if (!rddone && (wd_q == TO_LAST)) begin
          to_s    = 1'b1;
          wd_nx_s = 32'd0;
        end else begin
          wd_nx_s = wd_q + 32'd1;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        wd_nx_s    = 32'd0;
      end
    endcase
    close_s = rddone | to_s;
    pass_s  = (err_n == 8'd0) && (idx_n == DB7) && !to_s;
  end

  // Closing a round returns to IDLE and clears the working counters.
  always_comb begin
    state_d = state_nx_s;
    wd_d    = wd_nx_s;
    idx_d   = idx_n;
    err_d   = err_n;
    ferr_d  = ferr_n;
    fidx_d  = fidx_n;
    fdata_d = fdata_n;
    if (close_s) begin
      state_d = ST_IDLE;
      wd_d    = 32'd0;
      idx_d   = 7'd0;
      err_d   = 8'd0;
      ferr_d  = 1'b0;
      fidx_d  = 6'd0;
      fdata_d = 8'd0;
    end else begin
      state_d = state_nx_s;
      wd_d    = wd_nx_s;
    end
  end

  // Round state and working counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wd_q    <= 32'd0;
      idx_q   <= 7'd0;
      err_q   <= 8'd0;
      ferr_q  <= 1'b0;
      fidx_q  <= 6'd0;
      fdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      fidx_q  <= fidx_d;
      fdata_q <= fdata_d;
    end
  end

  // Publish the whole result set together, including the closing byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_vld_q     <= 1'b0;
      pass_q           <= 1'b0;
      fail_sticky_q    <= 1'b0;
      timeout_q        <= 1'b0;
      err_cnt_q        <= 8'd0;
      rx_cnt_q         <= 7'd0;
      first_err_idx_q  <= 6'd0;
      first_err_data_q <= 8'd0;
      round_cnt_q      <= 16'd0;
      led_rnd_q        <= 1'b0;
    end else begin
      result_vld_q <= close_s;
      if (close_s) begin
        pass_q           <= pass_s;
        fail_sticky_q    <= fail_sticky_q | ~pass_s;
        timeout_q        <= to_s;
        err_cnt_q        <= err_n;
        rx_cnt_q         <= idx_n;
        first_err_idx_q  <= fidx_n;
        first_err_data_q <= fdata_n;
        round_cnt_q      <= round_cnt_q + 16'd1;
        led_rnd_q        <= ~led_rnd_q;
      end
    end
  end

  flash_verify_led_heartbeat #(
    .HB_CYCLES(HB_CYCLES)
  ) u_heartbeat (
    .clk   (clk),
    .rst   (rst),
    .led_o (hb_led_s)
  );

  assign result_vld     = result_vld_q;
  assign pass           = pass_q;
  assign fail_sticky    = fail_sticky_q;
  assign timeout        = timeout_q;
  assign err_cnt        = err_cnt_q;
  assign rx_cnt         = rx_cnt_q;
  assign first_err_idx  = first_err_idx_q;
  assign first_err_data = first_err_data_q;
  assign round_cnt      = round_cnt_q;
  assign led            = {led_rnd_q, fail_sticky_q, pass_q, hb_led_s};

endmodule

// File: tb/tb_flash_verify.sv
`timescale 1ns/1ps
// Self-checking bench for flash_verify with a round-level reference model.
module tb_flash_verify;

  localparam int DB  = 64;
  localparam int OFS = 4;
  localparam int TO  = 40;
  localparam int HB  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rddata;
  logic        rddata_vld;
  logic        rddone;
  logic        result_vld, pass, fail_sticky, timeout;
  logic [7:0]  err_cnt, first_err_data;
  logic [6:0]  rx_cnt;
  logic [5:0]  first_err_idx;
  logic [15:0] round_cnt;
  logic [3:0]  led;

  always #5 clk = ~clk;

  flash_verify #(
    .DATA_BYTE(DB), .PATTERN_OFS(OFS), .TIMEOUT(TO), .HB_CYCLES(HB)
  ) dut (
    .clk(clk), .rst(rst), .rddata(rddata), .rddata_vld(rddata_vld), .rddone(rddone),
    .result_vld(result_vld), .pass(pass), .fail_sticky(fail_sticky), .timeout(timeout),
    .err_cnt(err_cnt), .rx_cnt(rx_cnt), .first_err_idx(first_err_idx),
    .first_err_data(first_err_data), .round_cnt(round_cnt), .led(led)
  );

  int total = 0;
  int bad   = 0;
  int rv_pulses = 0;

  // Count every result_vld cycle seen by the bench.
  always @(negedge clk) begin
    if (result_vld === 1'b1) rv_pulses++;
  end

  // Reference model state.
  logic [7:0] bytes_a [0:127];
  int m_round;
  bit m_sticky, m_led3;
  int e_rx, e_err, e_fidx, e_fdata;
  bit e_pass, e_to;

  task automatic model_reset();
    m_round = 0; m_sticky = 1'b0; m_led3 = 1'b0;
    e_rx = 0; e_err = 0; e_fidx = 0; e_fdata = 0; e_pass = 1'b0; e_to = 1'b0;
  endtask

  // Expected result of a round of n bytes (from bytes_a), from the rules.
  task automatic model_round(input int n, input bit to);
    int mism;
    int first;
    mism = 0;
    first = -1;
    for (int i = 0; i < n; i++) begin
      if ((i >= DB) || (bytes_a[i] != 8'((i + OFS) % 256))) begin
        mism++;
        if (first < 0) first = i;
      end
    end
    e_rx    = (n < DB) ? n : DB;
    e_err   = (mism > 255) ? 255 : mism;
    e_fidx  = (first < 0) ? 0 : (((first < DB) ? first : DB) % 64);
    e_fdata = (first < 0) ? 0 : int'(bytes_a[first]);
    e_to    = to;
    e_pass  = (e_err == 0) && (e_rx == DB) && !to;
    m_round = (m_round + 1) % 65536;
    m_sticky = m_sticky | !e_pass;
    m_led3  = ~m_led3;
  endtask

  function automatic logic [51:0] obs_vec();
    return {result_vld, pass, fail_sticky, timeout, err_cnt, rx_cnt, first_err_idx,
            first_err_data, round_cnt, led[3:1]};
  endfunction

  function automatic logic [51:0] exp_vec();
    return {1'b1, e_pass, m_sticky, e_to, 8'(e_err), 7'(e_rx), 6'(e_fidx), 8'(e_fdata),
            16'(m_round), m_led3, m_sticky, e_pass};
  endfunction

  // One clock of input drive; returns #1 after the rising edge.
  task automatic cyc_drive(input logic v, input logic [7:0] d, input logic dn);
    rddata_vld = v; rddata = d; rddone = dn;
    @(posedge clk); #1;
    rddata_vld = 1'b0; rddone = 1'b0; rddata = 8'h00;
  endtask

  task automatic fill_good(input int n);
    for (int i = 0; i < n; i++) bytes_a[i] = 8'((i + OFS) % 256);
  endtask

  // Drive a round of n bytes; rddone either rides on the last byte or
  // follows separately. Ends #1 after the closing edge, model updated.
  task automatic play_round(input int n, input bit sep_done, input int gap_max);
    for (int i = 0; i < n; i++) begin
      if (i > 0 && gap_max > 0) repeat ($urandom_range(gap_max, 0)) cyc_drive(1'b0, 8'h00, 1'b0);
      cyc_drive(1'b1, bytes_a[i], (i == n - 1) && !sep_done);
    end
    if (sep_done || n == 0) begin
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) cyc_drive(1'b0, 8'h00, 1'b0);
      cyc_drive(1'b0, 8'h00, 1'b1);
    end
    model_round(n, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; rddata_vld = 1'b0; rddone = 1'b0; rddata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs_vec() !== 52'd0 || led !== 4'd0) begin
      bad++; $display("FAIL reset_state: got %h led=%b want 0", obs_vec(), led);
    end
    rst = 1'b0;
    model_reset();
    cyc_drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_good_round();
    int rv0;
    rv0 = rv_pulses;
    fill_good(DB);
    play_round(DB, 1'b1, 0);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL good_round: got %h want %h", obs_vec(), exp_vec());
    end
    total++;
    if (pass !== 1'b1 || round_cnt !== 16'd1 || rx_cnt !== 7'd64 || fail_sticky !== 1'b0) begin
      bad++; $display("FAIL good_round_fields: pass=%0d round=%0d rx=%0d sticky=%0d want 1 1 64 0",
                      pass, round_cnt, rx_cnt, fail_sticky);
    end
    cyc_drive(1'b0, 8'h00, 1'b0);
    total++;
    if (result_vld !== 1'b0 || rv_pulses - rv0 != 1) begin
      bad++; $display("FAIL good_round_pulse: vld=%0d pulses=%0d want 0 1", result_vld, rv_pulses - rv0);
    end
  endtask

  task automatic test_corrupt();
    fill_good(DB);
    bytes_a[5] = 8'hFF;
    bytes_a[9] = 8'h00;
    play_round(DB, 1'b1, 2);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL corrupt: got %h want %h", obs_vec(), exp_vec());
    end
    total++;
    if (err_cnt !== 8'd2 || first_err_idx !== 6'd5 || first_err_data !== 8'hFF ||
        pass !== 1'b0 || fail_sticky !== 1'b1) begin
      bad++; $display("FAIL corrupt_fields: err=%0d idx=%0d data=%h pass=%0d sticky=%0d want 2 5 ff 0 1",
                      err_cnt, first_err_idx, first_err_data, pass, fail_sticky);
    end
    cyc_drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_short();
    fill_good(10);
    play_round(10, 1'b1, 0);
    total++;
    if (obs_vec() !== exp_vec() || rx_cnt !== 7'd10 || err_cnt !== 8'd0 || pass !== 1'b0) begin
      bad++; $display("FAIL short_round: got %h want %h", obs_vec(), exp_vec());
    end
    cyc_drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_overrun();
    fill_good(DB + 1);
    play_round(DB + 1, 1'b0, 0);
    total++;
    if (obs_vec() !== exp_vec() || rx_cnt !== 7'd64 || err_cnt !== 8'd1 || pass !== 1'b0) begin
      bad++; $display("FAIL overrun: got %h want %h", obs_vec(), exp_vec());
    end
    cyc_drive(1'b0, 8'h00, 1'b0);
    total++;
    if (result_vld !== 1'b0) begin
      bad++; $display("FAIL overrun_pulse: vld=%0d want 0", result_vld);
    end
  endtask

  task automatic test_timeout();
    int k;
    fill_good(3);
    for (int i = 0; i < 3; i++) cyc_drive(1'b1, bytes_a[i], 1'b0);
    k = 0;
    while (result_vld !== 1'b1 && k < TO + 10) begin
      cyc_drive(1'b0, 8'h00, 1'b0);
      k++;
    end
    model_round(3, 1'b1);
    total++;
    if (k != TO) begin
      bad++; $display("FAIL timeout_latency: idle cycles=%0d want %0d", k, TO);
    end
    total++;
    if (obs_vec() !== exp_vec() || timeout !== 1'b1 || rx_cnt !== 7'd3) begin
      bad++; $display("FAIL timeout_round: got %h want %h", obs_vec(), exp_vec());
    end
    cyc_drive(1'b0, 8'h00, 1'b0);
    fill_good(DB);
    play_round(DB, 1'b1, 3);
    total++;
    if (obs_vec() !== exp_vec() || pass !== 1'b1 || timeout !== 1'b0 || fail_sticky !== 1'b1) begin
      bad++; $display("FAIL after_timeout: got %h want %h", obs_vec(), exp_vec());
    end
    cyc_drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid();
    int rv0;
    fill_good(DB);
    for (int i = 0; i < 20; i++) cyc_drive(1'b1, bytes_a[i], 1'b0);
    rv0 = rv_pulses;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    repeat (2) cyc_drive(1'b0, 8'h00, 1'b0);
    total++;
    if (obs_vec() !== 52'd0 || led[3:1] !== 3'd0 || rv_pulses != rv0) begin
      bad++; $display("FAIL reset_mid: got %h pulses=%0d want 0 %0d", obs_vec(), rv_pulses, rv0);
    end
    play_round(DB, 1'b1, 0);
    total++;
    if (obs_vec() !== exp_vec() || round_cnt !== 16'd1) begin
      bad++; $display("FAIL reset_mid_next: got %h want %h", obs_vec(), exp_vec());
    end
    cyc_drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back();
    int rv0;
    rv0 = rv_pulses;
    fill_good(DB);
    play_round(DB, 1'b0, 0);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL b2b_first: got %h want %h", obs_vec(), exp_vec());
    end
    // Next round starts in the result_vld cycle.
    bytes_a[0] = 8'h77;
    play_round(DB, 1'b0, 0);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL b2b_second: got %h want %h", obs_vec(), exp_vec());
    end
    cyc_drive(1'b0, 8'h00, 1'b0);
    total++;
    if (rv_pulses - rv0 != 2) begin
      bad++; $display("FAIL b2b_pulses: got %0d want 2", rv_pulses - rv0);
    end
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 12; r++) begin
      n = (r == 0) ? 0 : $urandom_range(70, 1);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(12, 0) == 0) bytes_a[i] = 8'($urandom);
        else bytes_a[i] = 8'((i + OFS) % 256);
      end
      play_round(n, 1'($urandom_range(1, 0)), 5);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL random_round %0d (n=%0d): got %h want %h", r, n, obs_vec(), exp_vec());
      end
      repeat ($urandom_range(2, 0)) cyc_drive(1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic test_heartbeat();
    logic prev;
    int k, k2;
    prev = led[0];
    k = 0;
    while (led[0] === prev && k < 3 * HB) begin cyc_drive(1'b0, 8'h00, 1'b0); k++; end
    prev = led[0];
    k2 = 0;
    while (led[0] === prev && k2 < 3 * HB) begin cyc_drive(1'b0, 8'h00, 1'b0); k2++; end
    total++;
    if (k >= 3 * HB || k2 != HB) begin
      bad++; $display("FAIL heartbeat_period: got %0d want %0d", k2, HB);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_good_round();
    test_corrupt();
    test_short();
    test_overrun();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_heartbeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
